// File: rtl/nmr_clk_pkg.sv
// Shared constants and state encoding for the burst clock divider.
// Imported by the divider top and its handshake interface.
package nmr_clk_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle of the burst clock divider.
// The master drives configuration and commands, the slave reports status.
interface clk_div_ctrl_if
  import nmr_clk_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic clk_sys
);

  logic               cfg_wr;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               clk_out;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    input  clk_sys,
    output cfg_wr,
    output cfg_half,
    output cfg_burst,
    output start,
    output stop,
    input  clk_out,
    input  busy,
    input  done,
    input  cfg_err
  );

  modport slave (
    input  clk_sys,
    input  cfg_wr,
    input  cfg_half,
    input  cfg_burst,
    input  start,
    input  stop,
    output clk_out,
    output busy,
    output done,
    output cfg_err
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser with rising-edge detect on the synchronised level.
// rise_pulse is one clk_sys cycle wide per rising edge of async_in.
module edge_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
    end
  end

  assign rise_pulse = sync1_q & ~sync2_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Burst clock divider: divides the 5 MHz reference by 2*half and emits
// a programmable number of output periods (0 = free running).
module clk_div_ctrl
  import nmr_clk_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               clk_5M,
  input  logic               cfg_wr,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  logic tick;

  edge_sync u_sync (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .async_in   (clk_5M),
    .rise_pulse (tick)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]   hrun_q, hrun_d;
  logic [BURST_W-1:0] brun_q, brun_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] per_q, per_d;
  logic               clk_q, clk_d;
  logic               vld_q, vld_d;
  logic               err_d;
  logic               busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    burst_d = burst_q;
    hrun_d  = hrun_q;
    brun_d  = brun_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    clk_d   = clk_q;
    vld_d   = vld_q;
    err_d   = 1'b0;

    if (cfg_wr) begin
      if (state_q == S_IDLE && cfg_half != '0) begin
        half_d  = cfg_half;
        burst_d = cfg_burst;
        vld_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        // A run snapshots the config held before this cycle's write.
        if (start) begin
          if (vld_q) begin
            state_d = S_ARM;
            hrun_d  = half_q;
            brun_d  = burst_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_IDLE;
          clk_d   = 1'b0;
        end else if (tick) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(1);
          clk_d   = 1'b0;
          per_d   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          clk_d   = 1'b0;
        end else if (tick) begin
          if (cnt_q == hrun_q) begin
            cnt_d = CNT_W'(1);
            clk_d = ~clk_q;
            if (clk_q) begin
              per_d = per_q + BURST_W'(1);
              if (brun_q != '0 && per_d == brun_q) begin
                state_d = S_DONE;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        clk_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      burst_q <= '0;
      hrun_q  <= '0;
      brun_q  <= '0;
      cnt_q   <= CNT_W'(1);
      per_q   <= '0;
      clk_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      burst_q <= burst_d;
      hrun_q  <= hrun_d;
      brun_q  <= brun_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      clk_q   <= clk_d;
      vld_q   <= vld_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  assign clk_out = clk_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule
